// File: rtl/exec_tick_sched.sv
// Run/step/halt controller producing a one-cycle execution enable every div_reg clocks,
// with saturating tick and busy-tick performance counters.
module exec_tick_sched #(
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_we,
    input  logic             start,
    input  logic             step,
    input  logic             halt,
    input  logic             proc_busy,
    input  logic             proc_done,
    output logic             tick,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] tick_count,
    output logic [CNT_W-1:0] busy_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED,
        S_DONE
    } state_t;

    localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             clr;
    logic             wrap;

    assign wrap = (pre_q == (div_q - ONE_D));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pre_d   = '0;
        tick_d  = 1'b0;
        clr     = 1'b0;

        // Divide ratio is frozen while ticks are being generated.
        if (cfg_we && state_q != S_RUN && state_q != S_STEP)
            div_d = (cfg_div == '0) ? ONE_D : cfg_div;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    clr     = 1'b1;
                end else if (step) begin
                    state_d = S_STEP;
                    clr     = 1'b1;
                end
            end
            S_HALTED: begin
                if (proc_done)  state_d = S_DONE;
                else if (halt)  state_d = S_HALTED;
                else if (start) state_d = S_RUN;
                else if (step)  state_d = S_STEP;
            end
            S_RUN, S_STEP: begin
                if (proc_done) begin
                    state_d = S_DONE;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else if (wrap) begin
                    tick_d = 1'b1;
                    if (state_q == S_STEP) state_d = S_HALTED;
                end else begin
                    pre_d = pre_q + ONE_D;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tcnt_d = tcnt_q;
        bcnt_d = bcnt_q;
        if (clr) begin
            tcnt_d = '0;
            bcnt_d = '0;
        end else if (tick_d) begin
            if (tcnt_q != '1)              tcnt_d = tcnt_q + ONE_C;
            if (proc_busy && bcnt_q != '1) bcnt_d = bcnt_q + ONE_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= DIV_W'(DEFAULT_DIV);
            pre_q   <= '0;
            tick_q  <= 1'b0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign tick       = tick_q;
    assign running    = (state_q == S_RUN) || (state_q == S_STEP);
    assign done       = (state_q == S_DONE);
    assign tick_count = tcnt_q;
    assign busy_count = bcnt_q;

endmodule

// File: tb/tb_exec_tick_sched.sv
// Bench for exec_tick_sched: table-driven start-up run, hand-written corner sequences,
// then randomized traffic against an elapsed-cycle reference model. A CNT_W=4 copy checks saturation.
module tb_exec_tick_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_div;
    logic       cfg_we, start, step, halt, proc_busy, proc_done;
    logic        tick, running, done;
    logic [31:0] tick_count, busy_count;
    logic        s_tick, s_running, s_done;
    logic [3:0]  s_tick_count, s_busy_count;

    int n_cmp = 0;
    int n_bad = 0;

    exec_tick_sched dut (
        .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_we(cfg_we), .start(start),
        .step(step), .halt(halt), .proc_busy(proc_busy), .proc_done(proc_done),
        .tick(tick), .running(running), .done(done),
        .tick_count(tick_count), .busy_count(busy_count)
    );

    exec_tick_sched #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_we(cfg_we), .start(start),
        .step(step), .halt(halt), .proc_busy(proc_busy), .proc_done(proc_done),
        .tick(s_tick), .running(s_running), .done(s_done),
        .tick_count(s_tick_count), .busy_count(s_busy_count)
    );

    always #5 clk = ~clk;

    // Reference model: ticks fall on every div-th edge since entering run/step.
    typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT, M_DONE} mstate_t;
    mstate_t m_st;
    int      m_div, m_el;
    bit      m_tick;
    longint  m_tc, m_bc;

    function automatic longint sat(longint v, int w);
        longint lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_div = 4; m_el = 0; m_tick = 0; m_tc = 0; m_bc = 0;
    endtask

    task automatic model_edge();
        bit nt = 0;
        if (cfg_we && m_st != M_RUN && m_st != M_STEP)
            m_div = (cfg_div == 0) ? 1 : int'(cfg_div);
        case (m_st)
            M_IDLE, M_DONE: begin
                if (start)     begin m_st = M_RUN;  m_el = 0; m_tc = 0; m_bc = 0; end
                else if (step) begin m_st = M_STEP; m_el = 0; m_tc = 0; m_bc = 0; end
            end
            M_HALT: begin
                if (proc_done)  m_st = M_DONE;
                else if (halt)  m_st = M_HALT;
                else if (start) begin m_st = M_RUN;  m_el = 0; end
                else if (step)  begin m_st = M_STEP; m_el = 0; end
            end
            default: begin
                if (proc_done)  m_st = M_DONE;
                else if (halt)  m_st = M_HALT;
                else begin
                    m_el++;
                    if (m_el % m_div == 0) begin
                        nt = 1;
                        m_tc++;
                        if (proc_busy) m_bc++;
                        if (m_st == M_STEP) m_st = M_HALT;
                    end
                end
            end
        endcase
        m_tick = nt;
    endtask

    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("m_tick",    tick,       m_tick);
        chk("m_running", running,    (m_st == M_RUN || m_st == M_STEP));
        chk("m_done",    done,       (m_st == M_DONE));
        chk("m_tcnt",    tick_count, sat(m_tc, 32));
        chk("m_bcnt",    busy_count, sat(m_bc, 32));
        chk("m_s_tcnt",  s_tick_count, sat(m_tc, 4));
        chk("m_s_bcnt",  s_busy_count, sat(m_bc, 4));
        chk("m_s_tick",  s_tick,     m_tick);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk_model();
    endtask

    typedef struct {
        bit start;
        bit busy;
        bit e_tick;
        bit e_run;
        int e_tc;
        int e_bc;
    } vec_t;

    vec_t tv[13];

    initial begin
        tv[0]  = '{1, 1, 0, 1, 0, 0};
        tv[1]  = '{0, 1, 0, 1, 0, 0};
        tv[2]  = '{0, 1, 0, 1, 0, 0};
        tv[3]  = '{0, 1, 0, 1, 0, 0};
        tv[4]  = '{0, 1, 1, 1, 1, 1};
        tv[5]  = '{0, 1, 0, 1, 1, 1};
        tv[6]  = '{0, 1, 0, 1, 1, 1};
        tv[7]  = '{0, 1, 0, 1, 1, 1};
        tv[8]  = '{0, 1, 1, 1, 2, 2};
        tv[9]  = '{0, 1, 0, 1, 2, 2};
        tv[10] = '{0, 1, 0, 1, 2, 2};
        tv[11] = '{0, 1, 0, 1, 2, 2};
        tv[12] = '{0, 1, 1, 1, 3, 3};

        rst = 1; cfg_div = 0; cfg_we = 0; start = 0; step = 0;
        halt = 0; proc_busy = 0; proc_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_tcnt", tick_count, 0);
        chk("rst_bcnt", busy_count, 0);
        @(negedge clk);
        rst = 0;

        // start at E0, div=4, busy held high
        for (int i = 0; i < 13; i++) begin
            start = tv[i].start; proc_busy = tv[i].busy;
            cyc();
            chk($sformatf("tv%0d_tick", i), tick, tv[i].e_tick);
            chk($sformatf("tv%0d_run", i), running, tv[i].e_run);
            chk($sformatf("tv%0d_tcnt", i), tick_count, tv[i].e_tc);
            chk($sformatf("tv%0d_bcnt", i), busy_count, tv[i].e_bc);
        end
        start = 0;

        // halt lands on the edge that would have ticked
        repeat (3) cyc();
        halt = 1; cyc(); halt = 0;
        chk("halt_tick", tick, 0);
        chk("halt_running", running, 0);
        chk("halt_tcnt", tick_count, 3);
        start = 1; cyc(); start = 0;
        chk("resume_running", running, 1);
        repeat (3) cyc();
        chk("resume_notick", tick, 0);
        cyc();
        chk("resume_tick", tick, 1);
        chk("resume_tcnt", tick_count, 4);
        chk("resume_bcnt", busy_count, 4);

        // single steps at div=2 with proc_busy low
        halt = 1; cyc(); halt = 0;
        cfg_we = 1; cfg_div = 2; cyc(); cfg_we = 0;
        proc_busy = 0;
        for (int k = 0; k < 5; k++) begin
            step = 1; cyc(); step = 0;
            cyc();
            chk("step_wait", tick, 0);
            cyc();
            chk("step_tick", tick, 1);
            chk("step_halted", running, 0);
        end
        chk("step_tcnt", tick_count, 9);
        chk("step_bcnt", busy_count, 4);

        // proc_done and halt together: done wins, no tick
        proc_busy = 1;
        start = 1; cyc(); start = 0;
        cyc();
        proc_done = 1; halt = 1; cyc(); proc_done = 0; halt = 0;
        chk("pd_done", done, 1);
        chk("pd_tick", tick, 0);
        chk("pd_running", running, 0);
        chk("pd_tcnt", tick_count, 9);

        // div=0 stored as 1; reload attempt during RUN ignored
        cfg_we = 1; cfg_div = 0; cyc(); cfg_we = 0;
        start = 1; cyc(); start = 0;
        chk("restart_tcnt", tick_count, 0);
        chk("restart_bcnt", busy_count, 0);
        chk("restart_running", running, 1);
        chk("restart_done", done, 0);
        cyc();
        chk("div1_tick_e1", tick, 1);
        cfg_we = 1; cfg_div = 9; cyc(); cfg_we = 0;
        chk("div1_tick_e2", tick, 1);
        repeat (18) begin
            cyc();
            chk("div1_tick", tick, 1);
        end
        chk("sat_tcnt32", tick_count, 20);
        chk("sat_tcnt4", s_tick_count, 15);
        chk("sat_bcnt4", s_busy_count, 15);

        // asynchronous reset mid-run
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst_tick", tick, 0);
        chk("arst_running", running, 0);
        chk("arst_tcnt", tick_count, 0);
        chk("arst_bcnt", busy_count, 0);
        chk("arst_s_tcnt", s_tick_count, 0);
        @(negedge clk);
        rst = 0;
        start = 1; cyc(); start = 0;
        repeat (3) cyc();
        chk("arst_div4_wait", tick, 0);
        cyc();
        chk("arst_div4_tick", tick, 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 99) < 5);
            step      = ($urandom_range(0, 99) < 5);
            halt      = ($urandom_range(0, 99) < 3);
            proc_done = ($urandom_range(0, 99) < 2);
            proc_busy = $urandom_range(0, 1);
            cfg_we    = ($urandom_range(0, 99) < 6);
            cfg_div   = 8'($urandom_range(0, 5));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
